// File: rtl/ncore_ram_loader.sv
// ncore_ram_loader: receives a framed byte stream (SYNC, LEN, payload, CHK),
// writes the payload into the core's program RAM from address 0, optionally
// clears the rest of the RAM, verifies the checksum and then releases the core.
//
// Handshake: a byte moves on a rising edge only when in_valid and in_ready are
// both high in the cycle before that edge; in_valid may drop at any time to
// stall, and the loader holds all its state while it waits.
module ncore_ram_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter bit         ZERO_FILL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       core_hold,
  output logic       core_start,
  output logic       load_done,
  output logic       load_err,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_ZERO = 3'd3,
    S_CHK  = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t     state;
  // Nine bits so a 256-byte payload reaches its end count without wrapping.
  logic [8:0] cnt;
  logic [8:0] n_len;
  logic [7:0] sum;
  logic       start_q;
  logic       done_q;
  logic       err_q;

  logic       xfer;
  logic [8:0] cnt_nxt;
  logic [7:0] sum_nxt;

  assign in_ready  = ~rst & (state != S_ZERO);
  assign xfer      = in_valid & in_ready;
  assign cnt_nxt   = cnt + 9'd1;
  assign sum_nxt   = sum + in_data;

  assign core_hold  = rst | (state != S_DONE);
  assign core_start = start_q & ~rst;
  assign load_done  = done_q & ~rst;
  assign load_err   = err_q & ~rst;
  assign dbg_state  = state;

  // RAM write port: payload bytes pass straight through on the transfer
  // cycle; the clear pass writes zeros with no upstream involvement.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = 8'h00;
    ram_wdata = 8'h00;
    if (!rst) begin
      if (state == S_DATA && xfer) begin
        ram_we    = 1'b1;
        ram_addr  = cnt[7:0];
        ram_wdata = in_data;
      end else if (state == S_ZERO) begin
        ram_we    = 1'b1;
        ram_addr  = cnt[7:0];
      end
    end
  end

  // Frame sequencer with registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 9'd0;
      n_len   <= 9'd0;
      sum     <= 8'h00;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && in_data == SYNC_BYTE) state <= S_LEN;
        end
        S_LEN: begin
          if (xfer) begin
            // LEN of zero encodes a full 256-byte payload.
            n_len <= {in_data == 8'h00, in_data};
            cnt   <= 9'd0;
            sum   <= in_data;
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            cnt <= cnt_nxt;
            sum <= sum_nxt;
            if (cnt_nxt == n_len) begin
              if (ZERO_FILL && !n_len[8]) state <= S_ZERO;
              else                        state <= S_CHK;
            end
          end
        end
        S_ZERO: begin
          cnt <= cnt_nxt;
          if (cnt[7:0] == 8'hFF) state <= S_CHK;
        end
        S_CHK: begin
          if (xfer) begin
            if (sum_nxt == 8'h00) begin
              state   <= S_DONE;
              start_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state   <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (xfer && in_data == SYNC_BYTE) begin
            state  <= S_LEN;
            done_q <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncore_ram_loader.sv
// Directed + randomized bench for ncore_ram_loader. A reference model derives
// the expected RAM write list and checksum verdict from the frame contents.
module tb_ncore_ram_loader;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       core_hold;
  logic       core_start;
  logic       load_done;
  logic       load_err;
  logic [2:0] dbg_state;

  int vectors;
  int miscompares;
  int start_cnt;

  logic [7:0]  pl_q[$];   // payload of the frame being sent
  logic [15:0] got_q[$];  // {addr, data} of every observed RAM write
  logic [15:0] exp_q[$];  // {addr, data} predicted by the model

  ncore_ram_loader #(.SYNC_BYTE(8'hA5), .ZERO_FILL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .core_hold(core_hold), .core_start(core_start),
    .load_done(load_done), .load_err(load_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write and start-pulse monitor
  always @(posedge clk) begin
    if (ram_we) got_q.push_back({ram_addr, ram_wdata});
    if (core_start) start_cnt = start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: offer one byte until it is accepted, with random stalls
  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    int  guard;
    bit  hs;
    guard = 0;
    hs    = 1'b0;
    while (!hs) begin
      @(negedge clk);
      in_data  = b;
      in_valid = ($urandom_range(0, 99) >= stall_pct);
      #1;
      hs = in_valid && in_ready;
      @(posedge clk);
      guard++;
      if (!hs && guard > 2000) begin
        vectors++;
        miscompares++;
        $error("FAIL timeout observed=%0d expected=accept", guard);
        hs = 1'b1;
      end
    end
  endtask

  // reference model: RAM image from payload, clear of the tail, verdict
  task automatic build_expected(output bit good, input logic [7:0] len, input logic [7:0] chk_b);
    int n;
    int total;
    n     = (len == 8'h00) ? 256 : int'(len);
    total = int'(len) + int'(chk_b);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({i[7:0], pl_q[i]});
      total += int'(pl_q[i]);
    end
    for (int i = n; i < 256; i++) exp_q.push_back({i[7:0], 8'h00});
    good = ((total % 256) == 0);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_wcount"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) chk({tag, "_write"}, got_q[i], exp_q[i]);
    end
    vectors++;
  endtask

  // send a full frame from pl_q and check writes and completion status
  task automatic run_frame(input string tag, input logic [7:0] len,
                           input logic [7:0] chk_b, input int stall_pct);
    bit good;
    int n;
    int s0;
    n = (len == 8'h00) ? 256 : int'(len);
    build_expected(good, len, chk_b);
    got_q.delete();
    send_byte(8'hA5, stall_pct);
    send_byte(len, stall_pct);
    for (int i = 0; i < n; i++) send_byte(pl_q[i], stall_pct);
    if (n < 256) begin
      @(negedge clk);
      #1 chk({tag, "_ready_zero"}, in_ready, 1'b0);
    end
    s0 = start_cnt;
    send_byte(chk_b, stall_pct);
    @(negedge clk);
    in_valid = 1'b0;
    compare_writes(tag);
    chk({tag, "_start"},     core_start, good);
    chk({tag, "_load_done"}, load_done, good);
    chk({tag, "_load_err"},  load_err, !good);
    chk({tag, "_core_hold"}, core_hold, !good);
    @(negedge clk);
    chk({tag, "_start_pulses"}, start_cnt - s0, good ? 1 : 0);
  endtask

  initial begin
    int  len;
    logic [7:0] s;
    vectors     = 0;
    miscompares = 0;
    start_cnt   = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready",     in_ready, 1'b0);
    chk("rst_we",        ram_we, 1'b0);
    chk("rst_addr",      ram_addr, 8'h00);
    chk("rst_core_hold", core_hold, 1'b1);
    chk("rst_start",     core_start, 1'b0);
    chk("rst_done",      load_done, 1'b0);
    chk("rst_err",       load_err, 1'b0);
    chk("rst_state",     dbg_state, 3'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1'b1);

    // short frame with zero fill, good checksum
    pl_q = '{8'h5C, 8'h10};
    run_frame("frame_good", 8'h02, 8'h92, 0);

    // same frame, bad checksum
    run_frame("frame_bad", 8'h02, 8'h93, 0);

    // junk ahead of the sync byte must be ignored
    got_q.delete();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    @(negedge clk);
    chk("junk_no_writes", got_q.size(), 0);
    chk("junk_err_held",  load_err, 1'b1);
    pl_q = '{8'h01, 8'h02, 8'h03};
    run_frame("frame_junk", 8'h03, 8'hF7, 0);

    // full 256-byte payload, no clear pass
    pl_q.delete();
    for (int i = 0; i < 256; i++) pl_q.push_back(i[7:0]);
    run_frame("frame_256", 8'h00, 8'h80, 0);

    // random payload sent unstalled, then with heavy stalls
    pl_q.delete();
    s = 8'h0B;
    for (int i = 0; i < 11; i++) begin
      pl_q.push_back(8'($urandom_range(0, 255)));
      s = s + pl_q[i];
    end
    run_frame("stall_off", 8'h0B, 8'(-s), 0);
    run_frame("stall_on",  8'h0B, 8'(-s), 50);

    // reset in the middle of the payload
    pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    got_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h08, 0);
    for (int i = 0; i < 3; i++) send_byte(pl_q[i], 0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    #1;
    chk("midrst_ready", in_ready, 1'b0);
    chk("midrst_we",    ram_we, 1'b0);
    chk("midrst_hold",  core_hold, 1'b1);
    @(negedge clk);
    chk("midrst_state", dbg_state, 3'd0);
    chk("midrst_done",  load_done, 1'b0);
    chk("midrst_wdata", ram_wdata, 8'h00);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_wcount", got_q.size(), 3);
    chk("midrst_w2", got_q[2], 16'h0233);
    s = 8'h08;
    for (int i = 0; i < 8; i++) s = s + pl_q[i];
    run_frame("after_rst", 8'h08, 8'(-s), 0);

    // randomized frames, random length and random checksum validity
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 40);
      pl_q.delete();
      s = 8'(len);
      for (int i = 0; i < len; i++) begin
        pl_q.push_back(8'($urandom_range(0, 255)));
        s = s + pl_q[i];
      end
      if ($urandom_range(0, 1) == 1) s = s + 8'($urandom_range(1, 255));
      run_frame("rand", 8'(len), 8'(-s), 30);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ncore_ram_loader.md
NCORE_RAM_LOADER -- requirements
Module: ncore_ram_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter ZERO_FILL, default 1, enables clearing of unloaded RAM addresses.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream byte valid.
REQ-006 SHALL have port in_data  input  8  upstream byte.
REQ-007 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-008 SHALL have port ram_we  output  1  write strobe to core RAM.
REQ-009 SHALL have port ram_addr  output  8  core RAM write address.
REQ-010 SHALL have port ram_wdata  output  8  core RAM write data.
REQ-011 SHALL have port core_hold  output  1  keeps core PC at 0 and halted while high.
REQ-012 SHALL have port core_start  output  1  one-cycle pulse releasing the core.
REQ-013 SHALL have port load_done  output  1  level: last frame loaded, checksum good.
REQ-014 SHALL have port load_err  output  1  level: last frame checksum bad.

Function
REQ-015 SHALL treat a byte as transferred only on a cycle with in_valid and in_ready both high.
REQ-016 SHALL accept frame: SYNC_BYTE, LEN, N payload bytes, CHK; N = LEN, except LEN=0 means N=256.
REQ-017 SHALL implement states IDLE, LEN, DATA, ZERO, CHK, DONE, ERR.
REQ-018 IDLE: discard every byte other than SYNC_BYTE; SYNC_BYTE -> LEN.
REQ-019 LEN: store LEN, clear address counter to 0, init running sum = LEN -> DATA.
REQ-020 DATA: each payload byte SHALL drive ram_we=1, ram_addr=counter, ram_wdata=byte in the same cycle as the transfer (combinational from the handshake, zero latency); counter increments by 1; sum += byte mod 256.
REQ-021 After the Nth payload byte: -> ZERO if ZERO_FILL=1 and N<256, else -> CHK.
REQ-022 ZERO: in_ready=0; one write per cycle, ram_wdata=0, addresses N..255 ascending; after address 255 -> CHK.
REQ-023 CHK: accept one byte; (sum + CHK) mod 256 == 0 -> DONE, else -> ERR.
REQ-024 On entry to DONE: core_start=1 for exactly one cycle, load_done=1, core_hold=0.
REQ-025 On entry to ERR: load_err=1, core_hold stays 1, core_start never asserts.
REQ-026 DONE/ERR: SYNC_BYTE starts a new frame -> LEN, clearing load_done/load_err and setting core_hold=1 in the cycle after the transfer; other bytes discarded.
REQ-027 in_ready SHALL be 1 in every state except ZERO and except while rst is high.
REQ-028 ram_we SHALL be 0 in all states except DATA (on transfer) and ZERO.
REQ-029 core_hold SHALL be 1 in every state except DONE.
REQ-030 Address counter SHALL be 9 bits internally so N=256 terminates without wrap; ram_addr is its low 8 bits.
REQ-031 in_valid low mid-frame SHALL stall with no timeout; state, counter, sum hold.

Reset
REQ-032 While rst is high: state=IDLE, in_ready=0, ram_we=0, ram_addr=0, ram_wdata=0, core_hold=1, core_start=0, load_done=0, load_err=0, counter=0, sum=0.
REQ-033 rst asserted mid-frame (any state) SHALL abort the frame on the next edge with no further RAM write; already-written bytes are not restored.

Verification
REQ-034 Frame A5 02 5C 10 92 -> writes addr0=5C, addr1=10, then 254 zero writes addr2..255 with in_ready=0, then CHK accepted, core_start one pulse, load_done=1, core_hold=0.
REQ-035 Same frame with CHK=93 -> all 256 writes occur, load_err=1, load_done=0, core_hold=1, no core_start pulse.
REQ-036 Bytes 00 FF 5A before A5 03 ... -> leading bytes dropped, no ram_we until first payload byte, frame loads normally.
REQ-037 LEN=00, 256 payload bytes 00..FF, CHK = two's-complement of their sum (0x80) -> addresses 0..255 written once each, no ZERO state, load_done=1.
REQ-038 in_valid toggled randomly during DATA -> writes only on handshake cycles, contents identical to the unstalled run.
REQ-039 rst pulsed after 3 payload bytes of LEN=08 frame -> outputs at reset values the following cycle, no further writes, next clean frame loads and sets load_done=1.
